axis_block_fifo_upsizer: RTL

AXIS_BLOCK_FIFO_UPSIZER -- requirements
Module: axis_block_fifo_upsizer

---
 rtl/axis_pkg.sv | 31 +++
 rtl/axis_fifo_ram.sv | 30 +++
 rtl/axis_block_fifo_upsizer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/axis_pkg.sv
// Shared helpers for the AXI-Stream width-conversion blocks.
package axis_pkg;

  // Ceiling log2; returns 0 for values 0 and 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // Number of narrow lanes packed into one wide word.
  function automatic int unsigned ratio_of(input int unsigned m_width, input int unsigned s_width);
    return (s_width == 0) ? 0 : m_width / s_width;
  endfunction

  // One keep bit per narrow lane.
  function automatic int unsigned keep_width(input int unsigned m_width, input int unsigned s_width);
    return ratio_of(m_width, s_width);
  endfunction

  // True when value is a non-zero power of two.
  function automatic bit is_pow2(input int unsigned value);
    return (value != 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port RAM, single clock, registered read data.
module axis_fifo_ram
  import axis_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned AW   = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port and registered read port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/axis_block_fifo_upsizer.sv
// AXI-Stream upsizer feeding a FIFO that releases words in committed blocks.
module axis_block_fifo_upsizer
  import axis_pkg::*;
#(
  parameter int unsigned DEPTH        = 64,
  parameter int unsigned S_DATA_WIDTH = 8,
  parameter int unsigned M_DATA_WIDTH = 32,
  parameter int unsigned USER_WIDTH   = 1,
  parameter int unsigned BLOCK_BIT    = 2,
  localparam int unsigned RATIO       = ratio_of(M_DATA_WIDTH, S_DATA_WIDTH),
  localparam int unsigned KEEP_WIDTH  = keep_width(M_DATA_WIDTH, S_DATA_WIDTH),
  localparam int unsigned CNT_WIDTH   = clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [S_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic [USER_WIDTH-1:0]   s_axis_tuser,
  output logic [M_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]   m_axis_tkeep,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [USER_WIDTH-1:0]   m_axis_tuser,
  output logic [CNT_WIDTH-1:0]    status_count
);

  localparam int unsigned AW          = clog2(DEPTH);
  localparam int unsigned PW          = AW + 1;
  localparam int unsigned LW          = clog2(RATIO);
  localparam int unsigned BW          = BLOCK_BIT + 1;
  localparam int unsigned BLOCK_WORDS = 1 << BLOCK_BIT;
  localparam int unsigned WW          = M_DATA_WIDTH + KEEP_WIDTH + 1 + USER_WIDTH;

  // Reject parameter sets the pointer and lane arithmetic cannot handle.
  if (DEPTH < 2 || !is_pow2(DEPTH) || DEPTH < BLOCK_WORDS) begin : g_bad_depth
    $error("axis_block_fifo_upsizer: DEPTH must be a power of 2, >= 2 and >= 2**BLOCK_BIT");
  end
  if (RATIO < 2 || !is_pow2(RATIO) || RATIO * S_DATA_WIDTH != M_DATA_WIDTH) begin : g_bad_ratio
    $error("axis_block_fifo_upsizer: M_DATA_WIDTH/S_DATA_WIDTH must be an exact power of 2 >= 2");
  end

  // Pointers: wr = next write slot, commit = end of releasable region,
  // rd = next RAM fetch, pop = words that left the output port.
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           commit_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [PW-1:0]           pop_ptr;

  logic [LW-1:0]           lane;
  logic [BW-1:0]           uncommitted;
  logic [M_DATA_WIDTH-1:0] stage_data;
  logic [KEEP_WIDTH-1:0]   stage_keep;
  logic [USER_WIDTH-1:0]   stage_user;

  logic                    full;
  logic                    s_fire;
  logic                    word_done;
  logic                    commit_now;
  logic [M_DATA_WIDTH-1:0] word_data;
  logic [KEEP_WIDTH-1:0]   word_keep;
  logic [USER_WIDTH-1:0]   word_user;
  logic [WW-1:0]           wr_word;

  logic                    pend;
  logic                    pop;
  logic                    fetch;
  logic [1:0]              stage_words;
  logic [WW-1:0]           rd_word;
  logic                    out_valid;
  logic [WW-1:0]           out_word;
  logic                    skid_valid;
  logic [WW-1:0]           skid_word;

  // Input packing and completion/commit decisions. Fullness counts every
  // word not yet popped, so the output stage is part of the capacity.
  always_comb begin
    full          = (wr_ptr[PW-1] != pop_ptr[PW-1]) && (wr_ptr[AW-1:0] == pop_ptr[AW-1:0]);
    s_axis_tready = !rst && !full;
    s_fire        = s_axis_tvalid && s_axis_tready;
    word_data     = stage_data | (M_DATA_WIDTH'(s_axis_tdata) << (int'(lane) * S_DATA_WIDTH));
    word_keep     = stage_keep | (KEEP_WIDTH'(1) << lane);
    word_user     = stage_user | s_axis_tuser;
    word_done     = s_fire && ((lane == LW'(RATIO - 1)) || s_axis_tlast);
    commit_now    = word_done && ((uncommitted == BW'(BLOCK_WORDS - 1)) || s_axis_tlast);
    wr_word       = {word_user, s_axis_tlast, word_keep, word_data};
  end

  // Lane staging, write pointer and block commit tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      commit_ptr  <= '0;
      lane        <= '0;
      uncommitted <= '0;
      stage_data  <= '0;
      stage_keep  <= '0;
      stage_user  <= '0;
    end else if (s_fire) begin
      if (word_done) begin
        wr_ptr     <= wr_ptr + PW'(1);
        lane       <= '0;
        stage_data <= '0;
        stage_keep <= '0;
        stage_user <= '0;
        if (commit_now) begin
          commit_ptr  <= wr_ptr + PW'(1);
          uncommitted <= '0;
        end else begin
          uncommitted <= uncommitted + BW'(1);
        end
      end else begin
        lane       <= lane + LW'(1);
        stage_data <= word_data;
        stage_keep <= word_keep;
        stage_user <= word_user;
      end
    end
  end

  // Fetch a committed word only if the two-entry output stage is sure to
  // have room when the RAM data lands next cycle.
  always_comb begin
    pop         = out_valid && m_axis_tready;
    stage_words = 2'(out_valid) + 2'(skid_valid) + 2'(pend) - 2'(pop);
    fetch       = (rd_ptr != commit_ptr) && (stage_words < 2'd2);
  end

  // Read and pop pointers plus the RAM read-in-flight flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      pop_ptr <= '0;
      pend    <= 1'b0;
    end else begin
      if (fetch) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (pop) begin
        pop_ptr <= pop_ptr + PW'(1);
      end
      pend <= fetch;
    end
  end

  axis_fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (word_done),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (wr_word),
    .rd_en   (fetch),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (rd_word)
  );

  // Output register with a one-word skid so back-to-back pops keep flowing.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_word   <= '0;
      skid_valid <= 1'b0;
      skid_word  <= '0;
    end else if (pop) begin
      if (skid_valid) begin
        out_word   <= skid_word;
        skid_valid <= pend;
        if (pend) begin
          skid_word <= rd_word;
        end
      end else begin
        out_valid <= pend;
        if (pend) begin
          out_word <= rd_word;
        end
      end
    end else if (pend) begin
      if (!out_valid) begin
        out_valid <= 1'b1;
        out_word  <= rd_word;
      end else begin
        skid_valid <= 1'b1;
        skid_word  <= rd_word;
      end
    end
  end

  // Port drive; valid and occupancy read as zero while reset is held.
  always_comb begin
    m_axis_tvalid = out_valid && !rst;
    {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata} = out_word;
    status_count  = rst ? '0 : CNT_WIDTH'(wr_ptr - pop_ptr);
  end

endmodule
